// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per clock, LSB first; done pulses NDIG cycles after accept.
// No backpressure: start is accepted only in IDLE or DONE and ignored while busy.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_out, c_msb, accept, last;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_comb begin
    accept = start && (state != S_RUN);
    last   = (cnt == CW'(NDIG - 1));
    a_dig  = a_q[cnt*DIGIT +: DIGIT];
    b_dig  = b_q[cnt*DIGIT +: DIGIT];
    {c_out, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out of the sum for any DIGIT.
    c_msb   = s_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    res_nxt = result;
    res_nxt[cnt*DIGIT +: DIGIT] = s_dig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      result <= res_nxt;
      carry  <= c_out;
      cnt    <= cnt + 1'b1;
      if (last) begin
        cout <= c_out;
        ovf  <= c_msb ^ c_out;
        zero <= (res_nxt == '0);
        neg  <= res_nxt[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at 16/4, 8/1 and 8/8: scoreboard of expected results popped on done.
// Directed plan vectors, back-to-back starts, reset abort and random 8-bit operations.
module tb_serial_addsub;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic        clk, rst;
  logic [2:0]  start_v, sub_v, busy_v, done_v, cout_v, ovf_v, zero_v, neg_v;
  logic [15:0] a16, b16, res16;
  logic [7:0]  a8a, b8a, res8a, a8b, b8b, res8b;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$], q1[$], q2[$];

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a16), .b(b16),
    .busy(busy_v[0]), .done(done_v[0]), .result(res16),
    .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]), .neg(neg_v[0]));

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8a (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a8a), .b(b8a),
    .busy(busy_v[1]), .done(done_v[1]), .result(res8a),
    .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]), .neg(neg_v[1]));

  serial_addsub #(.WIDTH(8), .DIGIT(8)) u8b (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a8b), .b(b8b),
    .busy(busy_v[2]), .done(done_v[2]), .result(res8b),
    .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]), .neg(neg_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int w_of(input int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic int nd_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: plain full-width add with the operand inverted for subtraction.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] mask, am, bb;
    logic [16:0] sum;
    exp_t        e;
    mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
    am     = a & mask;
    bb     = (s ? ~b : b) & mask;
    sum    = {1'b0, am} + {1'b0, bb} + {16'h0, s};
    e.res  = sum[15:0] & mask;
    e.cout = sum[w];
    e.ovf  = (am[w-1] == bb[w-1]) && (e.res[w-1] != am[w-1]);
    e.zero = (e.res == 16'h0);
    e.neg  = e.res[w-1];
    return e;
  endfunction

  function automatic exp_t observe(input int i);
    exp_t e;
    case (i)
      0:       e.res = res16;
      1:       e.res = {8'h00, res8a};
      default: e.res = {8'h00, res8b};
    endcase
    e.cout = cout_v[i];
    e.ovf  = ovf_v[i];
    e.zero = zero_v[i];
    e.neg  = neg_v[i];
    return e;
  endfunction

  task automatic push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(input int i, output exp_t e);
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic drive(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    case (i)
      0:       begin a16 = a;      b16 = b;      end
      1:       begin a8a = a[7:0]; b8a = b[7:0]; end
      default: begin a8b = a[7:0]; b8b = b[7:0]; end
    endcase
    sub_v[i]   = s;
    start_v[i] = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge after done has dropped.
  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    int n;
    drive(i, a, b, s);
    push(i, model(w_of(i), a, b, s));
    @(negedge clk);
    start_v[i] = 1'b0;
    n = 0;
    while (busy_v[i] === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("busy_cycles%0d", i), n, nd_of(i));
    chk($sformatf("done_pulse%0d", i), done_v[i], 1);
    @(negedge clk);
    chk($sformatf("done_drop%0d", i), done_v[i], 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        chk($sformatf("done_has_exp%0d", i), qsize(i) > 0, 1);
        if (qsize(i) > 0) begin
          pop(i, e);
          chk($sformatf("res_flags%0d", i), observe(i), e);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    rst = 1'b1;
    start_v = '0; sub_v = '0;
    a16 = '0; b16 = '0; a8a = '0; b8a = '0; a8b = '0; b8b = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_state%0d", i), {busy_v[i], done_v[i], observe(i)}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 16'h1234, 16'h0FFF, 1'b0);
    chk("plan_sum_2233", res16, 16'h2233);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0);
    run_op(0, 16'h0005, 16'h0007, 1'b1);
    run_op(0, 16'h8000, 16'h0001, 1'b1);

    // start held high: accepted at cycles 0,5,10,15 only, operands change every cycle
    for (int c = 0; c < 20; c++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      drive(0, ra, rb, rs);
      if (c % 5 == 0) push(0, model(16, ra, rb, rs));
      @(negedge clk);
      chk($sformatf("b2b_busy_c%0d", c), busy_v[0], (c % 5 != 4));
    end
    start_v[0] = 1'b0;
    @(negedge clk);

    // abort on the second RUN edge
    drive(0, 16'h0F0F, 16'h1111, 1'b0);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_zero", {busy_v[0], done_v[0], observe(0)}, 0);
    run_op(0, 16'h0F0F, 16'h1111, 1'b0);
    repeat (6) @(negedge clk);

    run_op(1, 16'h007F, 16'h0001, 1'b0);
    run_op(2, 16'h0080, 16'h0001, 1'b1);
    run_op(2, 16'h00FF, 16'h0001, 1'b0);
    for (int k = 0; k < 8; k++) begin
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom));
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("queue_drained%0d", i), qsize(i), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
